ascon_bdi_sequencer: RTL and testbench

- Upstream feeder for the Ascon AEAD core's key/bdi input port.
- Accepts a per-message command (lengths, mode flags) and a flat 32-bit word stream from a DMA or bus FIFO.
- Steers each word to the key or bdi port, tagging it with the correct segment type and driving bdi_eot and bdi_eoi.
- Removes segment bookkeeping from software; data passes through with zero latency.

---
 rtl/ascon_bdi_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_ascon_bdi_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_bdi_sequencer.sv
// Steers a flat 32-bit word stream into the Ascon key/bdi ports, tagging segments and eot/eoi.
// Define ASCON_SEQ_HASH_EN to build the hash path (cmd_hash_i); otherwise hash is ignored.
module ascon_bdi_sequencer #(
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned KEY_WORDS = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_new_key_i,
    input  logic             cmd_decrypt_i,
    input  logic             cmd_hash_i,
    input  logic [LEN_W-1:0] cmd_ad_words_i,
    input  logic [LEN_W-1:0] cmd_msg_words_i,
    input  logic [31:0]      din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    output logic [31:0]      key_o,
    output logic             key_valid_o,
    input  logic             key_ready_i,
    output logic [31:0]      bdi_o,
    output logic             bdi_valid_o,
    input  logic             bdi_ready_i,
    output logic [3:0]       bdi_type_o,
    output logic             bdi_eot_o,
    output logic             bdi_eoi_o,
    output logic             decrypt_o,
    output logic             hash_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_AD    = 4'h1;
    localparam logic [3:0] D_PTCT  = 4'h4;
    localparam logic [3:0] D_HASH  = 4'h7;
    localparam logic [3:0] D_TAG   = 4'h8;
    localparam logic [3:0] D_NONCE = 4'hD;

    localparam logic [LEN_W-1:0] KEY_LEN = LEN_W'(KEY_WORDS);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY, S_NONCE, S_AD, S_MSG, S_TAG, S_DONE
    } state_t;

    state_t           state, state_nxt, last_seg;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [LEN_W-1:0] ad_len, ad_nxt;
    logic [LEN_W-1:0] msg_len, msg_nxt;
    logic             dec, dec_nxt;
    logic             hash_q, hash_nxt, cmd_hash;
    logic             in_key, in_data, hs;
    logic [3:0]       type_nxt;
    logic             eot_nxt, eoi_nxt;

    // Words in the segment that state s streams.
    function automatic logic [LEN_W-1:0] seg_len(input state_t s, input logic [LEN_W-1:0] ad,
                                                 input logic [LEN_W-1:0] msg);
        case (s)
            S_KEY, S_NONCE, S_TAG: seg_len = KEY_LEN;
            S_AD:                  seg_len = ad;
            S_MSG:                 seg_len = msg;
            default:               seg_len = '0;
        endcase
    endfunction

    // Next non-empty segment after s.
    function automatic state_t next_seg(input state_t s, input logic [LEN_W-1:0] ad,
                                        input logic [LEN_W-1:0] msg, input logic to_tag);
        state_t after_msg;
        after_msg = to_tag ? S_TAG : S_DONE;
        case (s)
            S_KEY:   next_seg = S_NONCE;
            S_NONCE: next_seg = (ad != '0) ? S_AD : (msg != '0) ? S_MSG : after_msg;
            S_AD:    next_seg = (msg != '0) ? S_MSG : after_msg;
            S_MSG:   next_seg = after_msg;
            default: next_seg = S_DONE;
        endcase
    endfunction

    // Zero-latency pass-through of the word stream.
    assign in_key      = (state == S_KEY);
    assign in_data     = (state inside {S_NONCE, S_AD, S_MSG, S_TAG});
    assign key_o       = din_i;
    assign bdi_o       = din_i;
    assign key_valid_o = in_key && din_valid_i;
    assign bdi_valid_o = in_data && din_valid_i;
    assign din_ready_o = (in_key && key_ready_i) || (in_data && bdi_ready_i);
    assign hs          = (key_valid_o && key_ready_i) || (bdi_valid_o && bdi_ready_i);

`ifdef ASCON_SEQ_HASH_EN
    assign cmd_hash = cmd_hash_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hash_q <= 1'b0;
            hash_o <= 1'b0;
        end else begin
            hash_q <= hash_nxt;
            hash_o <= (state_nxt != S_IDLE) && hash_nxt;
        end
    end
`else
    logic unused_hash;
    assign unused_hash = cmd_hash_i;
    assign cmd_hash    = 1'b0;
    assign hash_q      = 1'b0;
    assign hash_o      = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ad_nxt    = ad_len;
        msg_nxt   = msg_len;
        dec_nxt   = dec;
        hash_nxt  = hash_q;
        case (state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    ad_nxt   = cmd_ad_words_i;
                    msg_nxt  = cmd_msg_words_i;
                    dec_nxt  = cmd_decrypt_i;
                    hash_nxt = cmd_hash;
                    if (cmd_hash)
                        state_nxt = (cmd_msg_words_i != '0) ? S_MSG : S_DONE;
                    else
                        state_nxt = cmd_new_key_i ? S_KEY : S_NONCE;
                    cnt_nxt = seg_len(state_nxt, ad_nxt, msg_nxt);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                if (hs) begin
                    if (cnt == ONE) begin
                        state_nxt = next_seg(state, ad_len, msg_len, dec && !hash_q);
                        cnt_nxt   = seg_len(state_nxt, ad_len, msg_len);
                    end else begin
                        cnt_nxt = cnt - ONE;
                    end
                end
            end
        endcase

        // Tag the word that will be presented next cycle.
        last_seg = (hash_nxt || msg_nxt != '0) ? S_MSG : (ad_nxt != '0) ? S_AD : S_NONCE;
        eot_nxt  = (state_nxt inside {S_NONCE, S_AD, S_MSG, S_TAG}) && (cnt_nxt == ONE);
        eoi_nxt  = eot_nxt && (state_nxt == last_seg);
        case (state_nxt)
            S_NONCE: type_nxt = D_NONCE;
            S_AD:    type_nxt = D_AD;
            S_MSG:   type_nxt = hash_nxt ? D_HASH : D_PTCT;
            S_TAG:   type_nxt = D_TAG;
            default: type_nxt = D_NULL;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ad_len      <= '0;
            msg_len     <= '0;
            dec         <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            decrypt_o   <= 1'b0;
            bdi_type_o  <= D_NULL;
            bdi_eot_o   <= 1'b0;
            bdi_eoi_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ad_len      <= ad_nxt;
            msg_len     <= msg_nxt;
            dec         <= dec_nxt;
            cmd_ready_o <= (state_nxt == S_IDLE);
            busy_o      <= (state_nxt != S_IDLE);
            done_o      <= (state_nxt == S_DONE);
            decrypt_o   <= (state_nxt != S_IDLE) && dec_nxt;
            bdi_type_o  <= type_nxt;
            bdi_eot_o   <= eot_nxt;
            bdi_eoi_o   <= eoi_nxt;
        end
    end

endmodule

// File: tb/tb_ascon_bdi_sequencer.sv
// Randomized bench for ascon_bdi_sequencer: per-command expected word lists built from segment rules.
module tb_ascon_bdi_sequencer;

    localparam int unsigned LEN_W = 16;
    localparam int unsigned KW    = 4;

    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_AD    = 4'h1;
    localparam logic [3:0] D_PTCT  = 4'h4;
    localparam logic [3:0] D_HASH  = 4'h7;
    localparam logic [3:0] D_TAG   = 4'h8;
    localparam logic [3:0] D_NONCE = 4'hD;

`ifdef ASCON_SEQ_HASH_EN
    localparam bit HASH_EN = 1'b1;
`else
    localparam bit HASH_EN = 1'b0;
`endif

    typedef struct packed {
        logic       is_key;
        logic [3:0] typ;
        logic       eot;
        logic       eoi;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_new_key, cmd_decrypt, cmd_hash;
    logic [LEN_W-1:0] cmd_ad_words, cmd_msg_words;
    logic [31:0]      din, key, bdi;
    logic             din_valid, din_ready, key_valid, key_ready, bdi_valid, bdi_ready;
    logic [3:0]       bdi_type;
    logic             bdi_eot, bdi_eoi, decrypt, hash, busy, done;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    ascon_bdi_sequencer #(.LEN_W(LEN_W), .KEY_WORDS(KW)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_new_key_i(cmd_new_key),
        .cmd_decrypt_i(cmd_decrypt), .cmd_hash_i(cmd_hash),
        .cmd_ad_words_i(cmd_ad_words), .cmd_msg_words_i(cmd_msg_words),
        .din_i(din), .din_valid_i(din_valid), .din_ready_o(din_ready),
        .key_o(key), .key_valid_o(key_valid), .key_ready_i(key_ready),
        .bdi_o(bdi), .bdi_valid_o(bdi_valid), .bdi_ready_i(bdi_ready),
        .bdi_type_o(bdi_type), .bdi_eot_o(bdi_eot), .bdi_eoi_o(bdi_eoi),
        .decrypt_o(decrypt), .hash_o(hash), .busy_o(busy), .done_o(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    task automatic add_seg(input bit k, input logic [3:0] t, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.is_key = k;
            e.typ    = t;
            e.eot    = !k && (i == n - 1);
            e.eoi    = 1'b0;
            q.push_back(e);
        end
    endtask

    // Build the expected word list, stream it with random gaps/stalls, then check DONE and return to IDLE.
    task automatic run_cmd(input bit nk, input bit dc, input bit hs_req, input int ad, input int msg,
                           input int vp, input int rp, input int abort_hs);
        exp_t e;
        bit   heff, hs;
        int   hs_cnt, cyc;
        heff   = HASH_EN && hs_req;
        hs_cnt = 0;
        cyc    = 0;
        q.delete();
        if (heff) begin
            add_seg(1'b0, D_HASH, msg);
        end else begin
            if (nk) add_seg(1'b1, D_NULL, KW);
            add_seg(1'b0, D_NONCE, KW);
            add_seg(1'b0, D_AD, ad);
            add_seg(1'b0, D_PTCT, msg);
            if (dc) add_seg(1'b0, D_TAG, KW);
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!q[i].is_key && q[i].typ != D_TAG) begin
                e = q[i];
                e.eoi = 1'b1;
                q[i] = e;
                break;
            end
        end

        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid     = 1'b1;
        cmd_new_key   = nk;
        cmd_decrypt   = dc;
        cmd_hash      = hs_req;
        cmd_ad_words  = LEN_W'(ad);
        cmd_msg_words = LEN_W'(msg);
        din_valid     = 1'b0;
        @(posedge clk);
        @(negedge clk);

        while (q.size() > 0) begin
            if (cyc > 4000) begin
                chk("stream_timeout", 32'(q.size()), 32'd0);
                break;
            end
            cmd_valid     = 1'($urandom_range(1));
            cmd_new_key   = 1'($urandom_range(1));
            cmd_decrypt   = 1'($urandom_range(1));
            cmd_hash      = 1'($urandom_range(1));
            cmd_ad_words  = LEN_W'($urandom);
            cmd_msg_words = LEN_W'($urandom);
            din_valid     = ($urandom_range(99) < vp);
            key_ready     = ($urandom_range(99) < rp);
            bdi_ready     = ($urandom_range(99) < rp);
            din           = $urandom;
            #1;
            e = q[0];
            chk("key_valid", 32'(key_valid), 32'(din_valid && e.is_key));
            chk("bdi_valid", 32'(bdi_valid), 32'(din_valid && !e.is_key));
            chk("din_ready", 32'(din_ready), 32'(e.is_key ? key_ready : bdi_ready));
            chk("busy", 32'(busy), 32'd1);
            chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            chk("decrypt_o", 32'(decrypt), 32'(dc));
            chk("hash_o", 32'(hash), 32'(heff));
            if (din_valid && e.is_key) begin
                chk("key_data", key, din);
            end else if (din_valid) begin
                chk("bdi_type", 32'(bdi_type), 32'(e.typ));
                chk("bdi_eot", 32'(bdi_eot), 32'(e.eot));
                chk("bdi_eoi", 32'(bdi_eoi), 32'(e.eoi));
                chk("bdi_data", bdi, din);
            end
            hs = din_valid && (e.is_key ? key_ready : bdi_ready);
            @(posedge clk);
            if (hs) begin
                void'(q.pop_front());
                hs_cnt++;
            end
            @(negedge clk);
            cyc++;
            if (abort_hs > 0 && hs_cnt == abort_hs) begin
                din_valid = 1'b1;
                bdi_ready = 1'b0;
                cmd_valid = 1'b0;
                rst       = 1'b1;
                #1;
                chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
                chk("rst_bdi_valid", 32'(bdi_valid), 32'd0);
                chk("rst_key_valid", 32'(key_valid), 32'd0);
                chk("rst_bdi_type", 32'(bdi_type), 32'(D_NULL));
                chk("rst_busy", 32'(busy), 32'd0);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end

        // DONE cycle: a command offered here must not be taken.
        cmd_valid = 1'b1;
        din_valid = 1'b1;
        key_ready = 1'b1;
        bdi_ready = 1'b1;
        #1;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("done_din_ready", 32'(din_ready), 32'd0);
        chk("done_bdi_valid", 32'(bdi_valid), 32'd0);
        chk("done_key_valid", 32'(key_valid), 32'd0);
        chk("done_type", 32'(bdi_type), 32'(D_NULL));
        chk("done_hash_o", 32'(hash), 32'(heff));
        chk("done_decrypt_o", 32'(decrypt), 32'(dc));
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        din_valid = 1'b0;
        #1;
        chk("idle_done_low", 32'(done), 32'd0);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_decrypt", 32'(decrypt), 32'd0);
        chk("idle_hash", 32'(hash), 32'd0);
        chk("idle_type", 32'(bdi_type), 32'(D_NULL));
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_new_key   = 1'b0;
        cmd_decrypt   = 1'b0;
        cmd_hash      = 1'b0;
        cmd_ad_words  = '0;
        cmd_msg_words = '0;
        din           = '0;
        din_valid     = 1'b0;
        key_ready     = 1'b0;
        bdi_ready     = 1'b0;
        #12;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_type", 32'(bdi_type), 32'(D_NULL));
        chk("reset_eot", 32'(bdi_eot), 32'd0);
        chk("reset_eoi", 32'(bdi_eoi), 32'd0);
        chk("reset_decrypt", 32'(decrypt), 32'd0);
        chk("reset_hash", 32'(hash), 32'd0);
        chk("reset_din_ready", 32'(din_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(1'b1, 1'b0, 1'b0, 2, 3, 100, 100, 0);
        run_cmd(1'b0, 1'b0, 1'b0, 0, 0, 100, 100, 0);
        run_cmd(1'b0, 1'b1, 1'b0, 1, 0, 100, 100, 0);
        run_cmd(1'b0, 1'b0, 1'b0, 1, 2, 60, 50, 0);
        run_cmd(1'b1, 1'b0, 1'b0, 5, 3, 100, 100, 10);
        run_cmd(1'b1, 1'b0, 1'b0, 2, 2, 100, 100, 0);
        run_cmd(1'b0, 1'b0, 1'b1, 0, 2, 100, 100, 0);
        run_cmd(1'b1, 1'b1, 1'b1, 3, 0, 100, 100, 0);
        run_cmd(1'b0, 1'b1, 1'b0, 0, 300, 100, 100, 0);
        for (int n = 0; n < 40; n++) begin
            run_cmd(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                    $urandom_range(0, 6), $urandom_range(0, 6),
                    $urandom_range(40, 100), $urandom_range(40, 100), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
